// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg
//   Shared types and constants for the SPI register bank: the frame FSM
//   state enum and the R/W bit encoding carried in the first frame bit.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,   // synchronised ncs high
        ST_CMD  = 3'd1,   // receiving R/W and address
        ST_DATA = 3'd2,   // receiving data bits
        ST_FULL = 3'd3,   // exactly one frame received
        ST_OVER = 3'd4    // more bits than one frame received
    } spi_state_e;

    localparam logic SPI_WRITE = 1'b1;
    localparam logic SPI_READ  = 1'b0;

endpackage

// File: rtl/spi_reg_bank_if.sv
// spi_reg_bank_if
//   SPI pin bundle between an external controller and the register bank.
//   sclk/ncs/copi : controller -> peripheral
//   cipo/cipo_oe  : peripheral -> controller (cipo_oe drives the pad enable)
interface spi_reg_bank_if;

    logic sclk;
    logic ncs;
    logic copi;
    logic cipo;
    logic cipo_oe;

    modport master (
        output sclk, ncs, copi,
        input  cipo, cipo_oe
    );

    modport slave (
        input  sclk, ncs, copi,
        output cipo, cipo_oe
    );

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Multi-flop synchroniser for one asynchronous input with edge pulses.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronised level
//   rise, fall : one-cycle pulses on synchronised level transitions
//   RST_VAL sets the idle level so that reset release raises no false edge.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   q_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain  <= {SYNC_STAGES{RST_VAL}};
            q_prev <= RST_VAL;
        end else begin
            chain  <= {chain[SYNC_STAGES-2:0], d};
            q_prev <= chain[SYNC_STAGES-1];
        end
    end

    assign q    = chain[SYNC_STAGES-1];
    assign rise =  q & ~q_prev;
    assign fall = ~q &  q_prev;

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank
//   SPI mode-0 register bank. Frames are R/W bit, address, data, MSB first,
//   oversampled in the clk domain. Writes commit on ncs rise only for a
//   well-formed frame; reads return the addressed register on cipo.
//   clk, rst_n : system clock, async active-low reset
//   spi        : SPI pins (slave modport)
//   regs_out   : flattened registers, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe  : one-cycle pulse on the register written
//   frame_err  : one-cycle pulse when a frame ends with a bad bit count
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    spi_reg_bank_if.slave                spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);

    localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned CMD_W   = 1 + ADDR_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_s;
    logic sclk_lvl_unused, ncs_lvl_unused, copi_rise_unused, copi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .d(spi.sclk),
        .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs_sync (
        .clk(clk), .rst_n(rst_n), .d(spi.ncs),
        .q(ncs_lvl_unused), .rise(ncs_rise), .fall(ncs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi_sync (
        .clk(clk), .rst_n(rst_n), .d(spi.copi),
        .q(copi_s), .rise(copi_rise_unused), .fall(copi_fall_unused)
    );

    spi_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [FRAME_W-1:0]  sr_q;
    logic [FRAME_W-1:0]  sr_next;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   out_sr_q;
    logic                oe_q;
    logic                skip_fall_q;

    logic                shift_en, at_cmd_end, rd_load, wr_commit, bad_end;
    logic [ADDR_W-1:0]   rd_addr, wr_addr;
    logic [DATA_W-1:0]   wr_data, rd_data;

    // ncs rise has priority: an sclk edge in the same cycle is ignored.
    assign shift_en   = sclk_rise && !ncs_rise && (state_q != ST_IDLE);
    assign sr_next    = {sr_q[FRAME_W-2:0], copi_s};
    assign at_cmd_end = (state_q == ST_CMD) && (cnt_q == CNT_W'(CMD_W - 1));
    assign rd_addr    = sr_next[ADDR_W-1:0];
    assign rd_load    = shift_en && at_cmd_end && (sr_next[CMD_W-1] == SPI_READ);

    assign wr_addr    = sr_q[DATA_W +: ADDR_W];
    assign wr_data    = sr_q[DATA_W-1:0];
    assign wr_commit  = ncs_rise && (state_q == ST_FULL) && (sr_q[FRAME_W-1] == SPI_WRITE);
    assign bad_end    = ncs_rise && (state_q inside {ST_CMD, ST_DATA, ST_OVER});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else if (ncs_rise) begin
            state_q <= ST_IDLE;
        end else if (ncs_fall) begin
            state_q <= ST_CMD;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else if (shift_en) begin
            sr_q <= sr_next;
            case (state_q)
                ST_CMD: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (at_cmd_end) state_q <= ST_DATA;
                end
                ST_DATA: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_W - 1)) state_q <= ST_FULL;
                end
                ST_FULL: state_q <= ST_OVER;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_data = regs_q[i];
        end
    end

    // The shifter loads on the last address rise, so the sclk fall that
    // follows belongs to the command phase; it is skipped to keep the MSB
    // on cipo for the first data rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sr_q    <= '0;
            oe_q        <= 1'b0;
            skip_fall_q <= 1'b0;
        end else if (ncs_rise) begin
            out_sr_q    <= '0;
            oe_q        <= 1'b0;
            skip_fall_q <= 1'b0;
        end else if (rd_load) begin
            out_sr_q    <= rd_data;
            oe_q        <= 1'b1;
            skip_fall_q <= 1'b1;
        end else if (sclk_fall && oe_q) begin
            if (skip_fall_q) skip_fall_q <= 1'b0;
            else             out_sr_q    <= out_sr_q << 1;
        end
    end

    assign spi.cipo    = out_sr_q[DATA_W-1];
    assign spi.cipo_oe = oe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_strobe <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= '0;
            frame_err <= bad_end;
            if (wr_commit) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (wr_addr == ADDR_W'(i)) begin
                        regs_q[i]    <= wr_data;
                        wr_strobe[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        regs_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_out[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

endmodule
